// File: rtl/fp2i_arb_pkg.sv
// Shared FP->int op codes plus the legal-op check and mode decode used by the arbiter.
package fp2i_arb_pkg;

    localparam logic [7:0] OP_CVTD   = 8'h20;
    localparam logic [7:0] OP_CVTE   = 8'h21;
    localparam logic [7:0] OP_CVTS   = 8'h22;
    localparam logic [7:0] OP_CVT32S = 8'h23;
    localparam logic [7:0] OP_CVT32D = 8'h24;
    localparam logic [7:0] OP_TBLD   = 8'h25;

    typedef struct packed {
        logic dbl;
        logic ext;
        logic sng;
        logic verbatim;
        logic is32b;
    } cvt_mode_t;

    function automatic logic fp2i_op_legal(input logic [7:0] op);
        return (op == OP_CVTD)   || (op == OP_CVTE)   || (op == OP_CVTS) ||
               (op == OP_CVT32S) || (op == OP_CVT32D) || (op == OP_TBLD);
    endfunction

    function automatic cvt_mode_t fp2i_op_decode(input logic [7:0] op);
        cvt_mode_t m;
        m          = '0;
        m.dbl      = (op == OP_CVTD) || (op == OP_CVT32D);
        m.ext      = (op == OP_CVTE);
        m.sng      = !(m.dbl || m.ext);
        m.verbatim = (op == OP_TBLD);
        m.is32b    = (op == OP_CVT32S) || (op == OP_CVT32D);
        return m;
    endfunction

endpackage

// File: rtl/fp2i_req_fifo.sv
// Two-entry per-requester request queue; head visible the cycle after push.
// Flush empties it at the clock edge; caller must not push when full or pop when empty.
module fp2i_req_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (cnt == 2'd2);
    assign empty    = (cnt == 2'd0);

endmodule

// File: rtl/fp2i_arb.sv
// fp2i_arb: round-robin arbiter from NREQ requester FIFOs into one FP->int convert unit.
// Response LAT non-stalled cycles after grant; req_rdy = FIFO not full, stall freezes grant and pipeline.
module fp2i_arb
    import fp2i_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int LAT  = 3,
    parameter int TAGW = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*8-1:0]    req_op,
    input  logic [NREQ*84-1:0]   req_data,
    input  logic [NREQ*TAGW-1:0] req_tag,
    input  logic                 flush,
    input  logic                 stall,
    output logic                 cvt_en,
    output logic [81:0]          cvt_A,
    output logic                 cvt_isDBL,
    output logic                 cvt_isEXT,
    output logic                 cvt_isSNG,
    output logic                 cvt_verbatim,
    output logic                 cvt_is32b,
    input  logic [63:0]          cvt_res,
    input  logic                 cvt_alt,
    output logic [NREQ-1:0]      rsp_vld,
    output logic [63:0]          rsp_data,
    output logic                 rsp_alt,
    output logic                 rsp_err,
    output logic [TAGW-1:0]      rsp_tag,
    output logic                 busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int EW  = 8 + 84 + TAGW;

    logic [NREQ-1:0] fifo_full;
    logic [NREQ-1:0] fifo_empty;
    logic [NREQ-1:0] fifo_push;
    logic [NREQ-1:0] fifo_pop;
    logic [EW-1:0]   fifo_head [NREQ];

    logic            gnt_any;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  rr_ptr;

    logic [7:0]      sel_op;
    logic [TAGW-1:0] sel_tag;
    logic            sel_legal;
    cvt_mode_t       sel_mode;

    logic [LAT-1:0]  pv;
    logic [LAT-1:0]  perr;
    logic [IDW-1:0]  pid  [LAT];
    logic [TAGW-1:0] ptag [LAT];
    logic            rsp_fire;

    // Ready is held low for the whole time reset is asserted.
    assign req_rdy   = ~fifo_full & {NREQ{rst}};
    assign fifo_push = req_vld & req_rdy;

    for (genvar g = 0; g < NREQ; g++) begin : g_fifo
        assign fifo_pop[g] = gnt_any && (gnt_idx == IDW'(g));

        fp2i_req_fifo #(.W(EW)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (fifo_push[g]),
            .push_dat ({req_op[8*g +: 8], req_data[84*g +: 84], req_tag[TAGW*g +: TAGW]}),
            .pop      (fifo_pop[g]),
            .head_dat (fifo_head[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g])
        );
    end

    // Search starts at rr_ptr, which always names the requester after the last grant.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!stall && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!gnt_any && !fifo_empty[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDW'(idx);
                end
            end
        end
    end

    assign sel_op    = fifo_head[gnt_idx][EW-1 -: 8];
    assign sel_tag   = fifo_head[gnt_idx][TAGW-1:0];
    assign sel_legal = fp2i_op_legal(sel_op);
    assign sel_mode  = fp2i_op_decode(sel_op);

    always_comb begin
        cvt_en       = 1'b0;
        cvt_A        = '0;
        cvt_isDBL    = 1'b0;
        cvt_isEXT    = 1'b0;
        cvt_isSNG    = 1'b0;
        cvt_verbatim = 1'b0;
        cvt_is32b    = 1'b0;
        if (gnt_any) begin
            cvt_en       = sel_legal;
            cvt_isDBL    = sel_mode.dbl;
            cvt_isEXT    = sel_mode.ext;
            cvt_isSNG    = sel_mode.sng;
            cvt_verbatim = sel_mode.verbatim;
            cvt_is32b    = sel_mode.is32b;
            // Extension bits travel only with double/extended formats; data[67:66] are never used.
            cvt_A[65:0]  = fifo_head[gnt_idx][TAGW +: 66];
            if (sel_mode.dbl || sel_mode.ext)
                cvt_A[81:66] = fifo_head[gnt_idx][TAGW+68 +: 16];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv     <= '0;
            rr_ptr <= '0;
        end else begin
            if (flush) begin
                pv <= '0;
            end else if (!stall) begin
                pv[0] <= gnt_any;
                for (int s = 1; s < LAT; s++) pv[s] <= pv[s-1];
            end
            if (gnt_any)
                rr_ptr <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            pid[0]  <= gnt_idx;
            ptag[0] <= sel_tag;
            perr[0] <= ~sel_legal;
            for (int s = 1; s < LAT; s++) begin
                pid[s]  <= pid[s-1];
                ptag[s] <= ptag[s-1];
                perr[s] <= perr[s-1];
            end
        end
    end

    assign rsp_fire = pv[LAT-1] && !stall && !flush;
    assign rsp_vld  = rsp_fire ? (NREQ'(1) << pid[LAT-1]) : '0;
    assign rsp_err  = rsp_fire && perr[LAT-1];
    assign rsp_data = (rsp_fire && !perr[LAT-1]) ? cvt_res : '0;
    assign rsp_alt  = rsp_fire && !perr[LAT-1] && cvt_alt;
    assign rsp_tag  = rsp_fire ? ptag[LAT-1] : '0;
    assign busy     = (|(~fifo_empty)) || (|pv);

endmodule

// File: tb/tb_fp2i_arb.sv
// Directed bench for fp2i_arb: grant/decode, round-robin order, stall, illegal op, FIFO full, flush and reset.
module tb_fp2i_arb;
    import fp2i_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int TAGW = 6;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ-1:0]      req_rdy;
    logic [NREQ*8-1:0]    req_op;
    logic [NREQ*84-1:0]   req_data;
    logic [NREQ*TAGW-1:0] req_tag;
    logic                 flush;
    logic                 stall;
    logic                 cvt_en;
    logic [81:0]          cvt_A;
    logic                 cvt_isDBL;
    logic                 cvt_isEXT;
    logic                 cvt_isSNG;
    logic                 cvt_verbatim;
    logic                 cvt_is32b;
    logic [63:0]          cvt_res;
    logic                 cvt_alt;
    logic [NREQ-1:0]      rsp_vld;
    logic [63:0]          rsp_data;
    logic                 rsp_alt;
    logic                 rsp_err;
    logic [TAGW-1:0]      rsp_tag;
    logic                 busy;

    int n_chk  = 0;
    int n_fail = 0;

    fp2i_arb #(.NREQ(NREQ), .LAT(3), .TAGW(TAGW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_op       (req_op),
        .req_data     (req_data),
        .req_tag      (req_tag),
        .flush        (flush),
        .stall        (stall),
        .cvt_en       (cvt_en),
        .cvt_A        (cvt_A),
        .cvt_isDBL    (cvt_isDBL),
        .cvt_isEXT    (cvt_isEXT),
        .cvt_isSNG    (cvt_isSNG),
        .cvt_verbatim (cvt_verbatim),
        .cvt_is32b    (cvt_is32b),
        .cvt_res      (cvt_res),
        .cvt_alt      (cvt_alt),
        .rsp_vld      (rsp_vld),
        .rsp_data     (rsp_data),
        .rsp_alt      (rsp_alt),
        .rsp_err      (rsp_err),
        .rsp_tag      (rsp_tag),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] op, input logic [83:0] data,
                           input logic [TAGW-1:0] tag);
        req_op[8*i +: 8]          = op;
        req_data[84*i +: 84]      = data;
        req_tag[TAGW*i +: TAGW]   = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_vld;
        int         exp_g;
        int         exp_r;

        rst = 1'b0; req_vld = '0; req_op = '0; req_data = '0; req_tag = '0;
        flush = 1'b0; stall = 1'b0; cvt_res = '0; cvt_alt = 1'b0;
        #2;
        chk("rst_req_rdy",  req_rdy,  0);
        chk("rst_cvt_en",   cvt_en,   0);
        chk("rst_rsp_vld",  rsp_vld,  0);
        chk("rst_rsp_err",  rsp_err,  0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy",     busy,     0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("post_rst_rdy", req_rdy, 3'b111);

        // Single cvtD on req0
        set_req(0, OP_CVTD, {16'hABCD, 68'hF_0123_4567_89AB_CDEF}, 6'd5);
        req_vld = 3'b001; cvt_res = 64'hDEAD_BEEF_0000_0005; cvt_alt = 1'b1;
        tick(); req_vld = '0; #1;
        chk("d_cvt_en", cvt_en, 1);
        chk("d_isDBL",  cvt_isDBL, 1);
        chk("d_isEXT",  cvt_isEXT, 0);
        chk("d_isSNG",  cvt_isSNG, 0);
        chk("d_is32b",  cvt_is32b, 0);
        chk("d_cvt_A",  cvt_A, {16'hABCD, 66'h3_0123_4567_89AB_CDEF});
        chk("d_rsp_g0", rsp_vld, 0);
        tick(); #1; chk("d_rsp_g1", rsp_vld, 0);
        tick(); #1; chk("d_rsp_g2", rsp_vld, 0);
        tick(); #1;
        chk("d_rsp_vld",  rsp_vld, 3'b001);
        chk("d_rsp_tag",  rsp_tag, 5);
        chk("d_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_0005);
        chk("d_rsp_alt",  rsp_alt, 1);
        chk("d_rsp_err",  rsp_err, 0);
        tick(); #1;
        chk("d_idle_rsp",  rsp_vld, 0);
        chk("d_idle_busy", busy, 0);

        // Round-robin from a fresh reset, all requesters always valid
        rst = 1'b0; #1;
        tick(); rst = 1'b1; #1;
        for (int i = 0; i < NREQ; i++) set_req(i, OP_CVTS, 84'(i), 6'(i));
        req_vld = 3'b111; cvt_alt = 1'b0; cvt_res = 64'h0123_4567_89AB_CDEF;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 7) req_vld = '0;
            #1;
            if (k <= 6) begin
                exp_g = (k - 1) % 3;
                chk("rr_gnt_en", cvt_en, 1);
                chk("rr_gnt_id", cvt_A, 82'(exp_g));
            end
            if (k >= 4) begin
                exp_r   = (k - 4) % 3;
                exp_vld = 3'b001 << exp_r;
                chk("rr_rsp_vld", rsp_vld, exp_vld);
                chk("rr_rsp_tag", rsp_tag, 6'(exp_r));
            end else begin
                chk("rr_rsp_early", rsp_vld, 0);
            end
        end

        // Flush with work in flight
        tick(); flush = 1'b1; #1;
        chk("fl_busy_before", busy, 1);
        chk("fl_no_gnt", cvt_en, 0);
        chk("fl_no_rsp", rsp_vld, 0);
        tick(); flush = 1'b0; #1;
        chk("fl_busy", busy, 0);
        chk("fl_rdy",  req_rdy, 3'b111);
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            chk("fl_quiet_rsp", rsp_vld, 0);
        end

        // Stall two cycles right after grant of cvtS on req0; req1 queued behind it
        set_req(0, OP_CVTS, {16'h5555, 68'h1}, 6'd10);
        req_vld = 3'b001;
        tick();
        set_req(1, OP_CVTS, 84'h2, 6'd11);
        req_vld = 3'b010; #1;
        chk("st_gnt_en", cvt_en, 1);
        chk("st_isSNG",  cvt_isSNG, 1);
        chk("st_isDBL",  cvt_isDBL, 0);
        chk("st_cvt_A",  cvt_A, 82'h1);
        tick(); req_vld = '0; stall = 1'b1; #1;
        chk("st_no_gnt1", cvt_en, 0);
        chk("st_no_rsp1", rsp_vld, 0);
        tick(); #1;
        chk("st_no_gnt2", cvt_en, 0);
        chk("st_no_rsp2", rsp_vld, 0);
        tick(); stall = 1'b0; #1;
        chk("st_gnt1_en", cvt_en, 1);
        chk("st_gnt1_A",  cvt_A, 82'h2);
        chk("st_rsp_g3",  rsp_vld, 0);
        tick(); #1; chk("st_rsp_g4", rsp_vld, 0);
        tick(); #1;
        chk("st_rsp0_vld", rsp_vld, 3'b001);
        chk("st_rsp0_tag", rsp_tag, 10);
        tick(); #1;
        chk("st_rsp1_vld", rsp_vld, 3'b010);
        chk("st_rsp1_tag", rsp_tag, 11);

        // Illegal op on req1
        tick();
        set_req(1, 8'hFF, 84'hFFF, 6'd33);
        req_vld = 3'b010; cvt_res = 64'hFFFF_FFFF_FFFF_FFFF; cvt_alt = 1'b1;
        tick(); req_vld = '0; #1;
        chk("il_cvt_en", cvt_en, 0);
        chk("il_busy",   busy, 1);
        tick(); tick(); #1;
        chk("il_rsp_early", rsp_vld, 0);
        tick(); #1;
        chk("il_rsp_vld",  rsp_vld, 3'b010);
        chk("il_rsp_err",  rsp_err, 1);
        chk("il_rsp_data", rsp_data, 0);
        chk("il_rsp_alt",  rsp_alt, 0);
        chk("il_rsp_tag",  rsp_tag, 33);

        // req2 pushes three ops under stall; the third waits for space
        tick();
        stall = 1'b1;
        set_req(2, OP_CVT32D, {16'h1111, 68'h7}, 6'd1);
        req_vld = 3'b100; #1;
        chk("ff_rdy0", req_rdy[2], 1);
        tick();
        set_req(2, OP_CVTE, {16'h2222, 68'h8}, 6'd2); #1;
        chk("ff_rdy1", req_rdy[2], 1);
        tick();
        set_req(2, OP_TBLD, {16'h3333, 68'h9}, 6'd3); #1;
        chk("ff_full_rdy",   req_rdy[2], 0);
        chk("ff_stall_gnt",  cvt_en, 0);
        tick(); stall = 1'b0; #1;
        chk("ff_still_full", req_rdy[2], 0);
        chk("ff_g0_en",    cvt_en, 1);
        chk("ff_g0_isDBL", cvt_isDBL, 1);
        chk("ff_g0_is32b", cvt_is32b, 1);
        chk("ff_g0_isSNG", cvt_isSNG, 0);
        chk("ff_g0_A",     cvt_A, {16'h1111, 66'h7});
        tick(); #1;
        chk("ff_rdy_again", req_rdy[2], 1);
        chk("ff_g1_en",     cvt_en, 1);
        chk("ff_g1_isEXT",  cvt_isEXT, 1);
        chk("ff_g1_A",      cvt_A, {16'h2222, 66'h8});
        tick(); req_vld = '0; #1;
        chk("ff_g2_en",   cvt_en, 1);
        chk("ff_g2_verb", cvt_verbatim, 1);
        chk("ff_g2_isSNG", cvt_isSNG, 1);
        chk("ff_g2_A",    cvt_A, 82'h9);

        // Reset while two ops are still in flight
        tick(); #1;
        chk("mr_rsp_vld", rsp_vld, 3'b100);
        chk("mr_rsp_tag", rsp_tag, 1);
        chk("mr_busy",    busy, 1);
        rst = 1'b0; #1;
        chk("mr_rst_rsp",  rsp_vld, 0);
        chk("mr_rst_busy", busy, 0);
        chk("mr_rst_rdy",  req_rdy, 0);
        chk("mr_rst_en",   cvt_en, 0);
        tick(); rst = 1'b1; #1;
        chk("mr_rel_busy", busy, 0);
        chk("mr_rel_rdy",  req_rdy, 3'b111);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("mr_quiet_rsp", rsp_vld, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
